// File: rtl/md_sched.sv
// rtl/md_sched.sv - multiply/divide scheduler owning HI/LO; optional madd/maddu under `MD_MADD_EN
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_UseMD,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        stall
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [31:0] res_hi, res_lo;
  logic        res_dz;

  logic        is_mul, is_div, is_madd, is_long;
  logic        can_issue, start;
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, uq_abs, ur_abs;
  logic [31:0] squot, srem, uquot, urem;
  logic [31:0] op_hi, op_lo;

  // Decode the E-stage op and decide whether a multi-cycle op starts now
  always_comb begin
    is_mul    = (E_MDOp == 4'd1) || (E_MDOp == 4'd2);
    is_div    = (E_MDOp == 4'd3) || (E_MDOp == 4'd4);
`ifdef MD_MADD_EN
    is_madd   = (E_MDOp == 4'd7) || (E_MDOp == 4'd8);
`else
    is_madd   = 1'b0;
`endif
    is_long   = is_mul || is_div || is_madd;
    can_issue = (state == IDLE) && !req;
    start     = can_issue && is_long;
  end

  // Arithmetic: 64-bit products, and signed divide built from magnitudes so
  // that 0x80000000 / -1 naturally yields 0x80000000 with zero remainder
  always_comb begin
    prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
    prod_u = {32'd0, E_A} * {32'd0, E_B};
    abs_a  = E_A[31] ? (32'd0 - E_A) : E_A;
    abs_b  = E_B[31] ? (32'd0 - E_B) : E_B;
    uq_abs = abs_a / abs_b;
    ur_abs = abs_a % abs_b;
    squot  = (E_A[31] ^ E_B[31]) ? (32'd0 - uq_abs) : uq_abs;
    srem   = E_A[31] ? (32'd0 - ur_abs) : ur_abs;
    uquot  = E_A / E_B;
    urem   = E_A % E_B;
  end

  // Select the result captured at issue for the pending HI/LO write
  always_comb begin
    op_hi = 32'd0;
    op_lo = 32'd0;
    case (E_MDOp)
      4'd1: {op_hi, op_lo} = prod_s;
      4'd2: {op_hi, op_lo} = prod_u;
      4'd3: begin op_hi = srem; op_lo = squot; end
      4'd4: begin op_hi = urem; op_lo = uquot; end
`ifdef MD_MADD_EN
      4'd7: {op_hi, op_lo} = {HI, LO} + prod_s;
      4'd8: {op_hi, op_lo} = {HI, LO} + prod_u;
`endif
      default: begin op_hi = 32'd0; op_lo = 32'd0; end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: start a long op from IDLE, return when the count expires
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 32'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: busy covers the issue cycle too so D-stage users stall at once
  always_comb begin
    busy  = (state == RUN) || start;
    stall = D_UseMD && busy;
  end

  // Counter, pending results and architectural HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 32'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_dz <= 1'b0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else begin
      if (start) begin
        res_hi <= op_hi;
        res_lo <= op_lo;
        res_dz <= is_div && (E_B == 32'd0);
        cnt    <= is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
      end else if (state == RUN) begin
        cnt <= cnt - 32'd1;
        if (cnt == 32'd1 && !res_dz) begin
          HI <= res_hi;
          LO <= res_lo;
        end
      end
      if (can_issue && E_MDOp == 4'd5) HI <= E_A;
      if (can_issue && E_MDOp == 4'd6) LO <= E_A;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - directed self-checking bench for md_sched
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [3:0]  E_MDOp;
  logic [31:0] E_A, E_B;
  logic        D_UseMD;
  logic [31:0] HI, LO;
  logic        busy, stall;

  int checks   = 0;
  int failures = 0;
  int nbusy, nbad;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req(req), .E_MDOp(E_MDOp), .E_A(E_A), .E_B(E_B),
    .D_UseMD(D_UseMD), .HI(HI), .LO(LO), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Issue one op, then count busy cycles (issue cycle included) until idle.
  // req is raised in the cycle whose busy index equals req_cyc (0 = issue cycle).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_md, input int req_cyc,
                        output int n_busy, output int n_stall_bad);
    E_MDOp = op; E_A = a; E_B = b; D_UseMD = use_md; req = (req_cyc == 0);
    n_busy = 0; n_stall_bad = 0;
    #1;
    while (busy && n_busy < 100) begin
      n_busy++;
      if (stall !== use_md) n_stall_bad++;
      @(posedge clk); #1;
      E_MDOp = 4'd0;
      req = (n_busy == req_cyc);
      #1;
    end
    if (n_busy == 0) begin
      @(posedge clk); #1;
      E_MDOp = 4'd0;
    end
    req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; E_MDOp = 4'd0; E_A = 32'd0; E_B = 32'd0; D_UseMD = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);

    // signed mult with mflo waiting in D
    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1, -1, nbusy, nbad);
    check("mult_busy", 32'(nbusy), 32'd6);
    check("mult_stall", 32'(nbad), 32'd0);
    check("mult_stall_done", 32'(stall), 32'd0);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFFA);
    D_UseMD = 1'b0;

    // back-to-back multu in first idle cycle
    run_op(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0, -1, nbusy, nbad);
    check("multu_busy", 32'(nbusy), 32'd6);
    check("multu_hi", HI, 32'h00000002);
    check("multu_lo", LO, 32'hFFFFFFFA);

    // signed div with req during RUN cycle 2
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 2, nbusy, nbad);
    check("div_busy", 32'(nbusy), 32'd11);
    check("div_lo", LO, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);

    // divide by zero leaves HI/LO alone
    run_op(4'd4, 32'd7, 32'd0, 1'b0, -1, nbusy, nbad);
    check("dz_busy", 32'(nbusy), 32'd11);
    check("dz_hi", HI, 32'hFFFFFFFF);
    check("dz_lo", LO, 32'hFFFFFFFD);

    // signed overflow corner
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1, nbusy, nbad);
    check("ovf_lo", LO, 32'h80000000);
    check("ovf_hi", HI, 32'h00000000);

    run_op(4'd4, 32'd100, 32'd7, 1'b0, -1, nbusy, nbad);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    // req suppresses mult issue
    run_op(4'd1, 32'd5, 32'd5, 1'b0, 0, nbusy, nbad);
    check("req_mult_busy", 32'(nbusy), 32'd0);
    check("req_mult_hi", HI, 32'd2);
    check("req_mult_lo", LO, 32'd14);

    // mthi / mtlo, including mtlo suppressed by req
    run_op(4'd5, 32'h12345678, 32'd0, 1'b0, -1, nbusy, nbad);
    check("mthi_busy", 32'(nbusy), 32'd0);
    check("mthi_hi", HI, 32'h12345678);
    run_op(4'd6, 32'hCAFEF00D, 32'd0, 1'b0, 0, nbusy, nbad);
    check("mtlo_req_lo", LO, 32'd14);
    run_op(4'd6, 32'hCAFEF00D, 32'd0, 1'b0, -1, nbusy, nbad);
    check("mtlo_lo", LO, 32'hCAFEF00D);
    check("mtlo_hi", HI, 32'h12345678);

    // unused op code
    run_op(4'd12, 32'd9, 32'd9, 1'b1, -1, nbusy, nbad);
    check("op12_busy", 32'(nbusy), 32'd0);
    check("op12_stall", 32'(stall), 32'd0);
    check("op12_lo", LO, 32'hCAFEF00D);
    D_UseMD = 1'b0;

    // maddu: accumulate with the macro, no-op without it
    run_op(4'd5, 32'h0, 32'd0, 1'b0, -1, nbusy, nbad);
    run_op(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0, -1, nbusy, nbad);
    run_op(4'd8, 32'd1, 32'd1, 1'b0, -1, nbusy, nbad);
`ifdef MD_MADD_EN
    check("maddu_busy", 32'(nbusy), 32'd6);
    check("maddu_hi", HI, 32'h1);
    check("maddu_lo", LO, 32'h0);
`else
    check("maddu_busy", 32'(nbusy), 32'd0);
    check("maddu_hi", HI, 32'h0);
    check("maddu_lo", LO, 32'hFFFFFFFF);
`endif

    // reset during a div in RUN discards it
    E_MDOp = 4'd4; E_A = 32'd100; E_B = 32'd7;
    @(posedge clk); #1;
    E_MDOp = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_hi", HI, 32'h0);
    check("mid_rst_lo", LO, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("late_hi", HI, 32'h0);
    check("late_lo", LO, 32'h0);
    check("late_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
